// File: rtl/pixel_packer_pkg.sv
// Shared image-pipeline constants and payload types.
// Used by the pixel packer and the stream stages around it.
package pixel_packer_pkg;

  localparam int unsigned LANES       = 4;
  localparam int unsigned PIX_W       = 8;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned FRAME_CNT_W = 16;
  localparam int unsigned LANE_IDX_W  = $clog2(LANES);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [LANES-1:0]  keep;
    logic              last;
  } axis_word_t;

  // Byte enables for lanes 0..idx inclusive.
  function automatic logic [LANES-1:0] keep_mask(input logic [LANE_IDX_W-1:0] idx);
    logic [LANES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      m[i] = (LANE_IDX_W'(i) <= idx);
    end
    return m;
  endfunction

endpackage

// File: rtl/pixel_packer.sv
// Packs an 8-bit pixel stream into 32-bit AXI-Stream words for DMA S2MM,
// with tlast on the frame's final word and a completed-frame counter.
module pixel_packer
  import pixel_packer_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 512,
  parameter int unsigned IMG_HEIGHT = 512
) (
  input  logic                   axi_clk,
  input  logic                   axi_reset_n,
  input  logic                   i_data_valid,
  input  logic [PIX_W-1:0]       i_data,
  output logic                   o_data_ready,
  output logic                   m_axis_tvalid,
  output logic [DATA_W-1:0]      m_axis_tdata,
  output logic [LANES-1:0]       m_axis_tkeep,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic                   o_frame_done,
  output logic [FRAME_CNT_W-1:0] o_frame_count
);

  localparam int unsigned PIX_TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned PIX_CNT_W = (PIX_TOTAL > 1) ? $clog2(PIX_TOTAL) : 1;

  logic [LANE_IDX_W-1:0]  byte_idx;
  logic [PIX_CNT_W-1:0]   pix_cnt;
  logic [DATA_W-1:0]      acc;
  logic [DATA_W-1:0]      merged;
  axis_word_t             out_w;
  logic                   out_valid;
  logic                   frame_done;
  logic [FRAME_CNT_W-1:0] frame_count;
  logic                   accept;
  logic                   frame_last;
  logic                   load;
  logic                   handshake;

  // Output stage can take a new word when empty or draining this cycle.
  assign o_data_ready = !out_valid || m_axis_tready;
  assign accept       = i_data_valid && o_data_ready;
  assign frame_last   = (pix_cnt == PIX_CNT_W'(PIX_TOTAL - 1));
  assign load         = accept && ((byte_idx == LANE_IDX_W'(LANES - 1)) || frame_last);
  assign handshake    = out_valid && m_axis_tready;

  // Accumulator with the incoming pixel dropped into its lane; upper lanes stay zero.
  always_comb begin
    merged = acc;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (byte_idx == LANE_IDX_W'(i)) begin
        merged[i*PIX_W +: PIX_W] = i_data;
      end
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      acc      <= '0;
      byte_idx <= '0;
      pix_cnt  <= '0;
    end else if (accept) begin
      if (load) begin
        acc      <= '0;
        byte_idx <= '0;
      end else begin
        acc      <= merged;
        byte_idx <= byte_idx + LANE_IDX_W'(1);
      end
      pix_cnt <= frame_last ? '0 : pix_cnt + PIX_CNT_W'(1);
    end
  end

  // A new load takes priority over retiring the current word.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      out_valid <= 1'b0;
      out_w     <= '0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_w.data <= merged;
      out_w.keep <= keep_mask(byte_idx);
      out_w.last <= frame_last;
    end else if (handshake) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= handshake && out_w.last;
      if (handshake && out_w.last) begin
        frame_count <= frame_count + FRAME_CNT_W'(1);
      end
    end
  end

  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_w.data;
  assign m_axis_tkeep  = out_w.keep;
  assign m_axis_tlast  = out_w.last;
  assign o_frame_done  = frame_done;
  assign o_frame_count = frame_count;

endmodule

// File: tb/tb_pixel_packer.sv
// Scoreboard bench for pixel_packer: three instances (4x2, 3x2, 1x1) run
// in parallel; a reference packer queues expected words, a monitor pops them.
module tb_pixel_packer;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic [2:0] rst, vld, rdy, tv, tl, tr, fd;
  logic [2:0][7:0]  dat;
  logic [2:0][31:0] td;
  logic [2:0][3:0]  tk;
  logic [2:0][15:0] fcnt;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int          n_tot[3] = '{8, 6, 1};
  int          pos[3];
  int          nb[3];
  logic [31:0] acc_m[3];
  bit          rnd_rdy[3];
  bit          prev_stall[3];
  bit          exp_done[3];
  exp_t        prev_w[3];
  logic [15:0] fc_m[3];

  always #5 clk = ~clk;

  pixel_packer #(.IMG_WIDTH(4), .IMG_HEIGHT(2)) dut_a (
    .axi_clk(clk), .axi_reset_n(rst[0]), .i_data_valid(vld[0]), .i_data(dat[0]),
    .o_data_ready(rdy[0]), .m_axis_tvalid(tv[0]), .m_axis_tdata(td[0]),
    .m_axis_tkeep(tk[0]), .m_axis_tlast(tl[0]), .m_axis_tready(tr[0]),
    .o_frame_done(fd[0]), .o_frame_count(fcnt[0]));

  pixel_packer #(.IMG_WIDTH(3), .IMG_HEIGHT(2)) dut_b (
    .axi_clk(clk), .axi_reset_n(rst[1]), .i_data_valid(vld[1]), .i_data(dat[1]),
    .o_data_ready(rdy[1]), .m_axis_tvalid(tv[1]), .m_axis_tdata(td[1]),
    .m_axis_tkeep(tk[1]), .m_axis_tlast(tl[1]), .m_axis_tready(tr[1]),
    .o_frame_done(fd[1]), .o_frame_count(fcnt[1]));

  pixel_packer #(.IMG_WIDTH(1), .IMG_HEIGHT(1)) dut_c (
    .axi_clk(clk), .axi_reset_n(rst[2]), .i_data_valid(vld[2]), .i_data(dat[2]),
    .o_data_ready(rdy[2]), .m_axis_tvalid(tv[2]), .m_axis_tdata(td[2]),
    .m_axis_tkeep(tk[2]), .m_axis_tlast(tl[2]), .m_axis_tready(tr[2]),
    .o_frame_done(fd[2]), .o_frame_count(fcnt[2]));

  task automatic chk(input string name, input int k, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %h expected %h at %0t", name, k, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int k, input exp_t e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qpop(input int k, output exp_t e);
    case (k)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  // Reference packer: four pixels per word, first pixel lowest byte, frame end flushes.
  task automatic model_px(input int k, input logic [7:0] px);
    exp_t e;
    acc_m[k] = acc_m[k] | (32'(px) << (8 * nb[k]));
    nb[k]++;
    pos[k]++;
    if (nb[k] == 4 || pos[k] == n_tot[k]) begin
      e.data = acc_m[k];
      e.keep = 4'((1 << nb[k]) - 1);
      e.last = (pos[k] == n_tot[k]);
      qpush(k, e);
      acc_m[k] = '0;
      nb[k] = 0;
      if (e.last) pos[k] = 0;
    end
  endtask

  task automatic step(input int k);
    @(posedge clk);
    #1;
    if (rnd_rdy[k]) tr[k] = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int k, input int n);
    vld[k] = 1'b0;
    repeat (n) step(k);
  endtask

  task automatic push_px(input int k, input logic [7:0] px);
    int tries;
    bit done;
    tries = 0;
    done  = 1'b0;
    vld[k] = 1'b1;
    dat[k] = px;
    while (!done) begin
      @(negedge clk);
      if (rst[k] && rdy[k]) begin
        model_px(k, px);
        done = 1'b1;
      end
      step(k);
      tries++;
      if (!done && tries > 2000) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout inst%0d: got no accept required accept", k);
        done = 1'b1;
      end
    end
  endtask

  task automatic reset_a();
    rst[0] = 1'b0;
    vld[0] = 1'b0;
    q0.delete();
    acc_m[0] = '0;
    nb[0]    = 0;
    pos[0]   = 0;
    repeat (3) step(0);
    rst[0] = 1'b1;
  endtask

  task automatic mon(input int k);
    exp_t w, e;
    w.data = td[k];
    w.keep = tk[k];
    w.last = tl[k];
    if (!rst[k]) begin
      chk("rst_out", k, 64'({tv[k], td[k], tk[k], tl[k], fd[k], fcnt[k]}), 64'd0);
      chk("rst_rdy", k, 64'(rdy[k]), 64'd1);
      prev_stall[k] = 1'b0;
      exp_done[k]   = 1'b0;
      fc_m[k]       = '0;
    end else begin
      chk("ready", k, 64'(rdy[k]), 64'(!tv[k] || tr[k]));
      chk("done", k, 64'(fd[k]), 64'(exp_done[k]));
      chk("count", k, 64'(fcnt[k]), 64'(fc_m[k]));
      if (prev_stall[k]) chk("hold", k, 64'({tv[k], w}), 64'({1'b1, prev_w[k]}));
      exp_done[k] = 1'b0;
      if (tv[k] && tr[k]) begin
        if (qsize(k) == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_word inst%0d: got %h expected no word", k, w);
        end else begin
          qpop(k, e);
          chk("word", k, 64'(w), 64'(e));
          if (e.last) begin
            exp_done[k] = 1'b1;
            fc_m[k]     = fc_m[k] + 16'd1;
          end
        end
      end
      prev_stall[k] = tv[k] && !tr[k];
      prev_w[k]     = w;
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) mon(k);
  end

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst = '0;
    vld = '0;
    tr  = '1;
    dat = '0;
    for (int k = 0; k < 3; k++) begin
      pos[k] = 0; nb[k] = 0; acc_m[k] = '0; rnd_rdy[k] = 1'b0;
      prev_stall[k] = 1'b0; exp_done[k] = 1'b0; fc_m[k] = '0; prev_w[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = '1;

    fork
      begin : drive_a
        for (int p = 1; p <= 8; p++) push_px(0, 8'(p));
        idle(0, 3);
        // Downstream stall with a full word waiting.
        tr[0] = 1'b0;
        for (int p = 1; p <= 4; p++) push_px(0, 8'(p));
        vld[0] = 1'b1;
        dat[0] = 8'h05;
        repeat (5) begin
          @(negedge clk);
          chk("stall_rdy", 0, 64'(rdy[0]), 64'd0);
          chk("stall_data", 0, 64'(td[0]), 64'h0403_0201);
          @(posedge clk);
          #1;
        end
        tr[0] = 1'b1;
        for (int p = 5; p <= 8; p++) push_px(0, 8'(p));
        idle(0, 3);
        // Reset with a stalled pending word, then with a partial word.
        for (int p = 'h30; p <= 'h33; p++) push_px(0, 8'(p));
        tr[0] = 1'b0;
        idle(0, 2);
        reset_a();
        tr[0] = 1'b1;
        push_px(0, 8'h55);
        push_px(0, 8'h66);
        reset_a();
        for (int p = 'hA0; p <= 'hA7; p++) push_px(0, 8'(p));
        idle(0, 3);
        rnd_rdy[0] = 1'b1;
        for (int f = 0; f < 25; f++) begin
          for (int p = 0; p < 8; p++) begin
            if ($urandom_range(0, 3) == 0) idle(0, $urandom_range(1, 3));
            push_px(0, 8'($urandom));
          end
        end
        rnd_rdy[0] = 1'b0;
        idle(0, 1);
        tr[0] = 1'b1;
      end
      begin : drive_b
        for (int p = 'h11; p <= 'h16; p++) push_px(1, 8'(p));
        idle(1, 2);
        rnd_rdy[1] = 1'b1;
        for (int f = 0; f < 20; f++) begin
          for (int p = 0; p < 6; p++) begin
            if ($urandom_range(0, 4) == 0) idle(1, $urandom_range(1, 2));
            push_px(1, 8'($urandom));
          end
        end
        rnd_rdy[1] = 1'b0;
        idle(1, 1);
        tr[1] = 1'b1;
      end
      begin : drive_c
        for (int i = 0; i < 65536; i++) push_px(2, 8'($urandom));
        idle(2, 4);
        @(negedge clk);
        chk("wrap", 2, 64'(fcnt[2]), 64'd0);
        step(2);
        push_px(2, 8'h5A);
        idle(2, 4);
        @(negedge clk);
        chk("post_wrap", 2, 64'(fcnt[2]), 64'd1);
        step(2);
      end
    join

    guard = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    chk("drain", 0, 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
